enemy_controller: RTL and testbench

ENEMY_CONTROLLER -- requirements
Module: enemy_controller

---
 rtl/enemy_pkg.sv | 44 ++++
 rtl/lfsr16.sv | 31 +++
 rtl/enemy_controller.sv | 241 ++++++++++++++++++++++++
 tb/tb_enemy_controller.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/enemy_pkg.sv
// -----------------------------------------------------------------------------
// enemy_pkg
// Shared definitions for the enemy controller slice:
//   - enemy_state_t    : controller FSM state encoding
//   - DIR_*            : movement command encoding driven on 'dir'
//   - DEF_*            : default parameter values used by enemy_controller
//   - max3()           : helper used to size the shared frame counter
//   - reverse_dir()    : flips the direction along its current axis
// -----------------------------------------------------------------------------
package enemy_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SPAWN  = 3'd1,
      WANDER = 3'd2,
      HIT    = 3'd3,
      DYING  = 3'd4
   } enemy_state_t;

   localparam logic [1:0] DIR_LEFT  = 2'd0;
   localparam logic [1:0] DIR_RIGHT = 2'd1;
   localparam logic [1:0] DIR_DOWN  = 2'd2;
   localparam logic [1:0] DIR_UP    = 2'd3;

   localparam int          DEF_HP_MAX       = 3;
   localparam int          DEF_WALK_FRAMES  = 32;
   localparam int          DEF_HIT_FRAMES   = 16;
   localparam int          DEF_DEATH_FRAMES = 30;
   localparam logic [15:0] DEF_LFSR_SEED    = 16'hACE1;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

   // Left<->right and down<->up differ only in bit 0.
   function automatic logic [1:0] reverse_dir(input logic [1:0] d);
      return {d[1], ~d[0]};
   endfunction

endpackage

// File: rtl/lfsr16.sv
// -----------------------------------------------------------------------------
// lfsr16
// 16-bit Fibonacci LFSR, taps 16,14,13,11 (maximal length). Advances on every
// Clk. A zero seed would lock the register at zero, so it is replaced by 1.
// Ports:
//   Clk   in   system clock
//   Reset in   synchronous active-high reset, loads seed
//   seed  in   16-bit reset value
//   q     out  current register contents
// -----------------------------------------------------------------------------
module lfsr16 (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [15:0] seed,
   output logic [15:0] q
);

   logic feedback;

   // Tap positions 16,14,13,11 map to bits 15,13,12,10.
   assign feedback = q[15] ^ q[13] ^ q[12] ^ q[10];

   always_ff @(posedge Clk) begin
      if (Reset) begin
         q <= (seed == 16'd0) ? 16'd1 : seed;
      end else begin
         q <= {q[14:0], feedback};
      end
   end

endmodule

// File: rtl/enemy_controller.sv
// -----------------------------------------------------------------------------
// enemy_controller
// Behaviour FSM for one enemy: spawns on request, wanders with a pseudo-random
// or player-seeking direction, takes hits with a short invulnerability window,
// plays a death sequence and despawns on a room change.
//
// All behaviour advances on the rising edge of frame_clk, detected in the Clk
// domain. The only exception is SPAWN, which lasts exactly one Clk after the
// spawn frame edge; 'spawn' is high for that single Clk and the datapath loads
// the start position while it is high (no back-pressure).
//
// Optional feature: define ENEMY_CHASE_EN to steer toward the player at each
// direction-change boundary instead of using the LFSR.
//
// Ports:
//   Clk, Reset           system clock, synchronous active-high reset
//   frame_clk            frame tick (level; rising edge acted on)
//   initialize           spawn request, sampled on a frame edge in IDLE
//   damage               weapon overlap, sampled on a frame edge in WANDER
//   room[2:0]            current room index
//   Enemy_X/Y[9:0]       enemy position from the movement datapath
//   Player_X/Y[9:0]      player position (chase builds only)
//   dir[1:0]             movement command (DIR_* encoding)
//   active               enemy alive and drawn
//   spawn                one-Clk start-position load pulse
//   hp[1:0]              remaining hit points
//   dying                high while in DYING
//   state_dbg            current FSM state (debug)
//   count_dbg            current frame counter (debug)
// -----------------------------------------------------------------------------
module enemy_controller
   import enemy_pkg::*;
#(
   parameter int          HP_MAX       = DEF_HP_MAX,
   parameter int          WALK_FRAMES  = DEF_WALK_FRAMES,
   parameter int          HIT_FRAMES   = DEF_HIT_FRAMES,
   parameter int          DEATH_FRAMES = DEF_DEATH_FRAMES,
   parameter logic [15:0] LFSR_SEED    = DEF_LFSR_SEED,
   localparam int         CNT_W        = $clog2(max3(WALK_FRAMES, HIT_FRAMES, DEATH_FRAMES)) + 1
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             frame_clk,
   input  logic             initialize,
   input  logic             damage,
   input  logic [2:0]       room,
   input  logic [9:0]       Enemy_X,
   input  logic [9:0]       Enemy_Y,
   input  logic [9:0]       Player_X,
   input  logic [9:0]       Player_Y,
   output logic [1:0]       dir,
   output logic             active,
   output logic             spawn,
   output logic [1:0]       hp,
   output logic             dying,
   output enemy_state_t     state_dbg,
   output logic [CNT_W-1:0] count_dbg
);

   localparam logic [CNT_W-1:0] WALK_LAST  = CNT_W'(WALK_FRAMES - 1);
   localparam logic [CNT_W-1:0] HIT_LAST   = CNT_W'(HIT_FRAMES - 1);
   localparam logic [CNT_W-1:0] DEATH_LAST = CNT_W'(DEATH_FRAMES - 1);
   localparam logic [CNT_W-1:0] CNT_SAT    = {CNT_W{1'b1}};

   enemy_state_t     state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [1:0]       hp_r, hp_n;
   logic [1:0]       dir_r, dir_n;
   logic             frame_q;
   logic [2:0]       room_q;
   logic [9:0]       pos_x_q, pos_y_q;
   logic             pos_valid;
   logic [15:0]      lfsr_q;

   logic             frame_edge;
   logic             room_changed;
   logic             stuck;
   logic [1:0]       new_dir;
   logic             unused_bits;

   lfsr16 u_lfsr (
      .Clk   (Clk),
      .Reset (Reset),
      .seed  (LFSR_SEED),
      .q     (lfsr_q)
   );

   assign frame_edge   = frame_clk & ~frame_q;
   assign room_changed = (room != room_q);
   // pos_valid stays low until the first frame edge after a spawn, so the
   // position left over from the previous life cannot trigger the stuck rule.
   assign stuck        = pos_valid && (Enemy_X == pos_x_q) && (Enemy_Y == pos_y_q);

`ifdef ENEMY_CHASE_EN
   logic [9:0] dx_abs, dy_abs;

   always_comb begin
      dx_abs  = (Player_X >= Enemy_X) ? (Player_X - Enemy_X) : (Enemy_X - Player_X);
      dy_abs  = (Player_Y >= Enemy_Y) ? (Player_Y - Enemy_Y) : (Enemy_Y - Player_Y);
      new_dir = DIR_LEFT;
      // Larger |delta| wins; a tie goes to the X axis.
      if (dx_abs >= dy_abs) begin
         new_dir = (Player_X > Enemy_X) ? DIR_RIGHT : DIR_LEFT;
      end else begin
         new_dir = (Player_Y > Enemy_Y) ? DIR_DOWN : DIR_UP;
      end
   end

   assign unused_bits = ^lfsr_q;
`else
   // The two low LFSR bits present at the boundary edge pick the new heading.
   assign new_dir     = lfsr_q[1:0];
   assign unused_bits = ^{Player_X, Player_Y, lfsr_q[15:2]};
`endif

   // ---------------------------------------------------------------------------
   // Next-state / next-value logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      hp_n    = hp_r;
      dir_n   = dir_r;

      unique case (state)
         IDLE: begin
            // initialize wins over damage; damage has no meaning here.
            if (frame_edge && initialize) begin
               state_n = SPAWN;
            end
         end

         SPAWN: begin
            state_n = WANDER;
            hp_n    = 2'(HP_MAX);
            cnt_n   = '0;
         end

         WANDER: begin
            if (frame_edge) begin
               if (room_changed) begin
                  state_n = IDLE;
                  hp_n    = 2'd0;
                  cnt_n   = '0;
               end else if (damage) begin
                  cnt_n = '0;
                  if (hp_r > 2'd1) begin
                     hp_n    = hp_r - 2'd1;
                     state_n = HIT;
                     dir_n   = reverse_dir(dir_r);
                  end else begin
                     hp_n    = 2'd0;
                     state_n = DYING;
                  end
               end else if (stuck) begin
                  dir_n = reverse_dir(dir_r);
                  cnt_n = '0;
               end else if (cnt == WALK_LAST) begin
                  dir_n = new_dir;
                  cnt_n = '0;
               end else begin
                  cnt_n = cnt + CNT_W'(1);
               end
            end
         end

         HIT: begin
            if (frame_edge) begin
               if (room_changed) begin
                  state_n = IDLE;
                  hp_n    = 2'd0;
                  cnt_n   = '0;
               end else if (cnt == HIT_LAST) begin
                  state_n = WANDER;
                  cnt_n   = '0;
               end else if (cnt != CNT_SAT) begin
                  cnt_n = cnt + CNT_W'(1);
               end
            end
         end

         DYING: begin
            if (frame_edge) begin
               if (room_changed || (cnt == DEATH_LAST)) begin
                  state_n = IDLE;
                  hp_n    = 2'd0;
                  cnt_n   = '0;
               end else if (cnt != CNT_SAT) begin
                  cnt_n = cnt + CNT_W'(1);
               end
            end
         end

         default: begin
            state_n = IDLE;
            hp_n    = 2'd0;
            cnt_n   = '0;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // State and latch registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state     <= IDLE;
         cnt       <= '0;
         hp_r      <= 2'd0;
         dir_r     <= DIR_LEFT;
         frame_q   <= 1'b0;
         room_q    <= 3'd0;
         pos_x_q   <= 10'd0;
         pos_y_q   <= 10'd0;
         pos_valid <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         hp_r    <= hp_n;
         dir_r   <= dir_n;
         frame_q <= frame_clk;
         if (frame_edge) begin
            room_q    <= room;
            pos_x_q   <= Enemy_X;
            pos_y_q   <= Enemy_Y;
            pos_valid <= 1'b1;
         end else if (state == SPAWN) begin
            pos_valid <= 1'b0;
         end
      end
   end

   assign dir       = dir_r;
   assign hp        = hp_r;
   assign active    = (state == WANDER) || (state == HIT) || (state == DYING);
   assign spawn     = (state == SPAWN);
   assign dying     = (state == DYING);
   assign state_dbg = state;
   assign count_dbg = cnt;

endmodule

// File: tb/tb_enemy_controller.sv
// -----------------------------------------------------------------------------
// tb_enemy_controller
// Self-checking bench for enemy_controller (default parameters). Build with
// ENEMY_CHASE_EN defined to check the chase heading at the walk boundary.
// -----------------------------------------------------------------------------
module tb_enemy_controller;
   import enemy_pkg::*;

   // ---------------- clock / reset ----------------
   logic Clk = 1'b0;
   logic Reset = 1'b1;
   always #5 Clk = ~Clk;

   logic       frame_clk  = 1'b0;
   logic       initialize = 1'b0;
   logic       damage     = 1'b0;
   logic [2:0] room       = 3'd2;
   logic [9:0] Enemy_X    = 10'd200;
   logic [9:0] Enemy_Y    = 10'd100;
   logic [9:0] Player_X   = 10'd300;
   logic [9:0] Player_Y   = 10'd120;

   logic [1:0]   dir, hp;
   logic         active, spawn, dying;
   enemy_state_t state_dbg;
   logic [5:0]   count_dbg;

   enemy_controller dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .frame_clk  (frame_clk),
      .initialize (initialize),
      .damage     (damage),
      .room       (room),
      .Enemy_X    (Enemy_X),
      .Enemy_Y    (Enemy_Y),
      .Player_X   (Player_X),
      .Player_Y   (Player_Y),
      .dir        (dir),
      .active     (active),
      .spawn      (spawn),
      .hp         (hp),
      .dying      (dying),
      .state_dbg  (state_dbg),
      .count_dbg  (count_dbg)
   );

   // ---------------- reference LFSR ----------------
   logic [15:0] m_lfsr;
   logic [15:0] edge_lfsr;
   always @(posedge Clk) begin
      if (Reset) m_lfsr <= 16'hACE1;
      else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
   end

   int spawn_cnt = 0;
   always @(negedge Clk) begin
      if (spawn) spawn_cnt = spawn_cnt + 1;
   end

   // ---------------- scoreboard ----------------
   int total = 0;
   int bad   = 0;
   logic [12:0] exp_q[$];   // {state[2:0], hp[1:0], active, dying, cnt[5:0]}

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One frame: frame_clk high for two Clk, low for two Clk. The LFSR value
   // the DUT sees at the frame edge is captured just before that edge.
   task automatic do_frame();
      @(negedge Clk);
      frame_clk = 1'b1;
      edge_lfsr = m_lfsr;
      @(negedge Clk);
      @(negedge Clk);
      frame_clk = 1'b0;
      @(negedge Clk);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic         init;
      logic         dmg;
      logic [2:0]   room;
      int           reps;
      enemy_state_t st;
      logic [1:0]   hp;
      logic         act;
      logic         dy;
      logic [5:0]   cnt;
   } vec_t;

   vec_t vecs[17];

   function automatic vec_t mk(input logic i, input logic d, input logic [2:0] r, input int n,
                               input enemy_state_t s, input logic [1:0] h, input logic a,
                               input logic y, input logic [5:0] c);
      vec_t v;
      v.init = i; v.dmg = d; v.room = r; v.reps = n;
      v.st = s; v.hp = h; v.act = a; v.dy = y; v.cnt = c;
      return v;
   endfunction

   logic [1:0]  exp_dir;
   logic [12:0] e;

   initial begin
      vecs[0]  = mk(1'b1, 1'b0, 3'd3,  1, WANDER, 2'd3, 1'b1, 1'b0, 6'd0);
      vecs[1]  = mk(1'b0, 1'b0, 3'd3, 19, WANDER, 2'd3, 1'b1, 1'b0, 6'd19);
      vecs[2]  = mk(1'b0, 1'b1, 3'd3,  1, HIT,    2'd2, 1'b1, 1'b0, 6'd0);
      vecs[3]  = mk(1'b0, 1'b1, 3'd3, 15, HIT,    2'd2, 1'b1, 1'b0, 6'd15);
      vecs[4]  = mk(1'b0, 1'b0, 3'd3,  1, WANDER, 2'd2, 1'b1, 1'b0, 6'd0);
      vecs[5]  = mk(1'b0, 1'b0, 3'd3,  3, WANDER, 2'd2, 1'b1, 1'b0, 6'd3);
      vecs[6]  = mk(1'b0, 1'b1, 3'd3,  1, HIT,    2'd1, 1'b1, 1'b0, 6'd0);
      vecs[7]  = mk(1'b0, 1'b0, 3'd3, 15, HIT,    2'd1, 1'b1, 1'b0, 6'd15);
      vecs[8]  = mk(1'b0, 1'b0, 3'd3,  1, WANDER, 2'd1, 1'b1, 1'b0, 6'd0);
      vecs[9]  = mk(1'b0, 1'b0, 3'd3,  3, WANDER, 2'd1, 1'b1, 1'b0, 6'd3);
      vecs[10] = mk(1'b0, 1'b1, 3'd3,  1, DYING,  2'd0, 1'b1, 1'b1, 6'd0);
      vecs[11] = mk(1'b0, 1'b0, 3'd3, 29, DYING,  2'd0, 1'b1, 1'b1, 6'd29);
      vecs[12] = mk(1'b0, 1'b0, 3'd3,  1, IDLE,   2'd0, 1'b0, 1'b0, 6'd0);
      vecs[13] = mk(1'b1, 1'b1, 3'd3,  1, WANDER, 2'd3, 1'b1, 1'b0, 6'd0);
      vecs[14] = mk(1'b1, 1'b0, 3'd3,  2, WANDER, 2'd3, 1'b1, 1'b0, 6'd2);
      vecs[15] = mk(1'b0, 1'b1, 3'd5,  1, IDLE,   2'd0, 1'b0, 1'b0, 6'd0);
      vecs[16] = mk(1'b0, 1'b0, 3'd5,  2, IDLE,   2'd0, 1'b0, 1'b0, 6'd0);

      // ---------------- reset ----------------
      repeat (3) @(negedge Clk);
      Reset = 1'b0;
      @(negedge Clk);
      check("rst_state", state_dbg, IDLE);
      check("rst_dir", dir, 2'd0);
      check("rst_hp", hp, 2'd0);
      check("rst_active", active, 1'b0);
      check("rst_spawn", spawn, 1'b0);
      check("rst_dying", dying, 1'b0);
      check("rst_cnt", count_dbg, 6'd0);

      // ---------------- spawn ----------------
      initialize = 1'b1;
      do_frame();
      initialize = 1'b0;
      check("spawn_pulses", spawn_cnt, 1);
      check("spawn_state", state_dbg, WANDER);
      check("spawn_hp", hp, 2'd3);
      check("spawn_active", active, 1'b1);
      check("spawn_dir", dir, 2'd0);

      // ---------------- walk boundary ----------------
      // Position moves every frame; the 32nd edge lands at (100,100).
      for (int k = 1; k <= 32; k++) begin
         Enemy_X = 10'(68 + k);
         do_frame();
         if (k < 32) check("walk_hold_dir", dir, 2'd0);
      end
`ifdef ENEMY_CHASE_EN
      exp_dir = DIR_RIGHT;
`else
      exp_dir = edge_lfsr[1:0];
`endif
      check("walk_new_dir", dir, exp_dir);
      check("walk_wrap_cnt", count_dbg, 6'd0);

      // ---------------- stuck rule ----------------
      do_frame();
      check("stuck1_dir", dir, exp_dir ^ 2'b01);
      check("stuck1_cnt", count_dbg, 6'd0);
      do_frame();
      check("stuck2_dir", dir, exp_dir);
      check("stuck2_cnt", count_dbg, 6'd0);

      // ---------------- hit with damage held ----------------
      Enemy_X = 10'd300;
      damage  = 1'b1;
      do_frame();
      check("hit_state", state_dbg, HIT);
      check("hit_hp", hp, 2'd2);
      check("hit_dir", dir, exp_dir ^ 2'b01);
      for (int k = 0; k < 15; k++) begin
         Enemy_X = Enemy_X + 10'd1;
         do_frame();
      end
      check("hit_hold_state", state_dbg, HIT);
      check("hit_hold_hp", hp, 2'd2);
      Enemy_X = Enemy_X + 10'd1;
      do_frame();
      check("hit_exit_state", state_dbg, WANDER);
      check("hit_exit_hp", hp, 2'd2);
      check("hit_exit_cnt", count_dbg, 6'd0);
      damage = 1'b0;

      // ---------------- room change ----------------
      room    = 3'd3;
      Enemy_X = Enemy_X + 10'd1;
      do_frame();
      check("room_state", state_dbg, IDLE);
      check("room_active", active, 1'b0);
      check("room_hp", hp, 2'd0);

      // ---------------- table-driven life cycle ----------------
      for (int i = 0; i < 17; i++) begin
         initialize = vecs[i].init;
         damage     = vecs[i].dmg;
         room       = vecs[i].room;
         for (int r = 0; r < vecs[i].reps; r++) begin
            if (r == vecs[i].reps - 1)
               exp_q.push_back({vecs[i].st, vecs[i].hp, vecs[i].act, vecs[i].dy, vecs[i].cnt});
            Enemy_X = Enemy_X + 10'd1;
            do_frame();
         end
         check("tbl_queue_ready", (exp_q.size() > 0), 1'b1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("tbl%0d_state", i), state_dbg, e[12:10]);
            check($sformatf("tbl%0d_hp", i), hp, e[9:8]);
            check($sformatf("tbl%0d_active", i), active, e[7]);
            check($sformatf("tbl%0d_dying", i), dying, e[6]);
            check($sformatf("tbl%0d_cnt", i), count_dbg, e[5:0]);
         end
      end
      initialize = 1'b0;
      damage     = 1'b0;
      check("tbl_spawn_pulses", spawn_cnt, 3);

      // ---------------- reset mid-HIT ----------------
      initialize = 1'b1;
      do_frame();
      initialize = 1'b0;
      damage     = 1'b1;
      Enemy_X    = Enemy_X + 10'd1;
      do_frame();
      damage = 1'b0;
      check("midhit_state", state_dbg, HIT);
      for (int k = 0; k < 3; k++) begin
         Enemy_X = Enemy_X + 10'd1;
         do_frame();
      end
      @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);
      @(negedge Clk);
      Reset = 1'b0;
      @(negedge Clk);
      check("midhit_rst_state", state_dbg, IDLE);
      check("midhit_rst_hp", hp, 2'd0);
      check("midhit_rst_dir", dir, 2'd0);
      check("midhit_rst_active", active, 1'b0);
      check("midhit_rst_cnt", count_dbg, 6'd0);

      check("queue_drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
